// File: rtl/sm4_pkg.sv
// Shared SM4 definitions: key-schedule constants, CK generation and the
// rotate / L' helpers used by both the key schedule and the round datapath.
package sm4_pkg;

  localparam int ROUNDS_MAX = 32;
  localparam int CNT_W      = $clog2(ROUNDS_MAX);

  localparam logic [31:0] FK0 = 32'hA3B1BAC6;
  localparam logic [31:0] FK1 = 32'h56AA3350;
  localparam logic [31:0] FK2 = 32'h677D9197;
  localparam logic [31:0] FK3 = 32'hB27022DC;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_RUN   = 2'd2,
    ST_FLUSH = 2'd3
  } ke_state_e;

  // n is expected in 1..31
  function automatic logic [31:0] rotl32(input logic [31:0] x, input int unsigned n);
    rotl32 = (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [31:0] l_key(input logic [31:0] b);
    l_key = b ^ rotl32(b, 13) ^ rotl32(b, 23);
  endfunction

  // CK_i byte j (j=0 is the MSB) = (4i+j)*7 with 8-bit wraparound
  function automatic logic [31:0] ck_word(input logic [CNT_W-1:0] i);
    logic [7:0]  base;
    logic [31:0] w;
    base = {1'b0, i, 2'b00};
    w    = '0;
    for (int j = 0; j < 4; j++) begin
      w[31-8*j -: 8] = (base + 8'(j)) * 8'd7;
    end
    ck_word = w;
  endfunction

endpackage

// File: rtl/sm4_sbox.sv
// SM4 byte substitution box, combinational table lookup.
module sm4_sbox (
  input  logic [7:0] in_i,
  output logic [7:0] out_o
);

  localparam logic [7:0] SBOX [256] = '{
    8'hD6, 8'h90, 8'hE9, 8'hFE, 8'hCC, 8'hE1, 8'h3D, 8'hB7, 8'h16, 8'hB6, 8'h14, 8'hC2, 8'h28, 8'hFB, 8'h2C, 8'h05,
    8'h2B, 8'h67, 8'h9A, 8'h76, 8'h2A, 8'hBE, 8'h04, 8'hC3, 8'hAA, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
    8'h9C, 8'h42, 8'h50, 8'hF4, 8'h91, 8'hEF, 8'h98, 8'h7A, 8'h33, 8'h54, 8'h0B, 8'h43, 8'hED, 8'hCF, 8'hAC, 8'h62,
    8'hE4, 8'hB3, 8'h1C, 8'hA9, 8'hC9, 8'h08, 8'hE8, 8'h95, 8'h80, 8'hDF, 8'h94, 8'hFA, 8'h75, 8'h8F, 8'h3F, 8'hA6,
    8'h47, 8'h07, 8'hA7, 8'hFC, 8'hF3, 8'h73, 8'h17, 8'hBA, 8'h83, 8'h59, 8'h3C, 8'h19, 8'hE6, 8'h85, 8'h4F, 8'hA8,
    8'h68, 8'h6B, 8'h81, 8'hB2, 8'h71, 8'h64, 8'hDA, 8'h8B, 8'hF8, 8'hEB, 8'h0F, 8'h4B, 8'h70, 8'h56, 8'h9D, 8'h35,
    8'h1E, 8'h24, 8'h0E, 8'h5E, 8'h63, 8'h58, 8'hD1, 8'hA2, 8'h25, 8'h22, 8'h7C, 8'h3B, 8'h01, 8'h21, 8'h78, 8'h87,
    8'hD4, 8'h00, 8'h46, 8'h57, 8'h9F, 8'hD3, 8'h27, 8'h52, 8'h4C, 8'h36, 8'h02, 8'hE7, 8'hA0, 8'hC4, 8'hC8, 8'h9E,
    8'hEA, 8'hBF, 8'h8A, 8'hD2, 8'h40, 8'hC7, 8'h38, 8'hB5, 8'hA3, 8'hF7, 8'hF2, 8'hCE, 8'hF9, 8'h61, 8'h15, 8'hA1,
    8'hE0, 8'hAE, 8'h5D, 8'hA4, 8'h9B, 8'h34, 8'h1A, 8'h55, 8'hAD, 8'h93, 8'h32, 8'h30, 8'hF5, 8'h8C, 8'hB1, 8'hE3,
    8'h1D, 8'hF6, 8'hE2, 8'h2E, 8'h82, 8'h66, 8'hCA, 8'h60, 8'hC0, 8'h29, 8'h23, 8'hAB, 8'h0D, 8'h53, 8'h4E, 8'h6F,
    8'hD5, 8'hDB, 8'h37, 8'h45, 8'hDE, 8'hFD, 8'h8E, 8'h2F, 8'h03, 8'hFF, 8'h6A, 8'h72, 8'h6D, 8'h6C, 8'h5B, 8'h51,
    8'h8D, 8'h1B, 8'hAF, 8'h92, 8'hBB, 8'hDD, 8'hBC, 8'h7F, 8'h11, 8'hD9, 8'h5C, 8'h41, 8'h1F, 8'h10, 8'h5A, 8'hD8,
    8'h0A, 8'hC1, 8'h31, 8'h88, 8'hA5, 8'hCD, 8'h7B, 8'hBD, 8'h2D, 8'h74, 8'hD0, 8'h12, 8'hB8, 8'hE5, 8'hB4, 8'hB0,
    8'h89, 8'h69, 8'h97, 8'h4A, 8'h0C, 8'h96, 8'h77, 8'h7E, 8'h65, 8'hB9, 8'hF1, 8'h09, 8'hC5, 8'h6E, 8'hC6, 8'h84,
    8'h18, 8'hF0, 8'h7D, 8'hEC, 8'h3A, 8'hDC, 8'h4D, 8'h20, 8'h79, 8'hEE, 8'h5F, 8'h3E, 8'hD7, 8'hCB, 8'h39, 8'h48
  };

  assign out_o = SBOX[in_i];

endmodule

// File: rtl/sm4_tau.sv
// SM4 nonlinear word transform tau: four parallel byte S-boxes.
module sm4_tau (
  input  logic [31:0] x_i,
  output logic [31:0] y_o
);

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    sm4_sbox u_sbox (
      .in_i  (x_i[8*g +: 8]),
      .out_o (y_o[8*g +: 8])
    );
  end

endmodule

// File: rtl/sm4_key_expand.sv
// Iterative SM4 key schedule: one round key per accepted cycle on a
// valid/ready stream, ROUNDS keys per run, done pulse on the last accept.
module sm4_key_expand
  import sm4_pkg::*;
#(
  parameter int ROUNDS = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] mkey,
  output logic         busy,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [31:0]  rk_out,
  output logic [4:0]   rk_index,
  output logic         done
);

  // Stream handshake: a key transfers on a cycle where rk_valid && rk_ready;
  // while rk_valid && !rk_ready every output and internal register holds.

  localparam logic [CNT_W-1:0] LAST    = CNT_W'(ROUNDS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  ke_state_e          state_q, state_d;
  logic [3:0][31:0]   k_q, k_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        rk_q, rk_d;
  logic [CNT_W-1:0]   idx_q, idx_d;
  logic               vld_q, vld_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [31:0]        tau_in, tau_out, rk_new;
  logic               advance;

  assign tau_in  = k_q[1] ^ k_q[2] ^ k_q[3] ^ ck_word(cnt_q);
  assign rk_new  = k_q[0] ^ l_key(tau_out);
  assign advance = !vld_q || rk_ready;

  sm4_tau u_tau (
    .x_i (tau_in),
    .y_o (tau_out)
  );

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    cnt_d   = cnt_q;
    rk_d    = rk_q;
    idx_d   = idx_q;
    vld_d   = vld_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          k_d[0]  = mkey[127:96] ^ FK0;
          k_d[1]  = mkey[95:64]  ^ FK1;
          k_d[2]  = mkey[63:32]  ^ FK2;
          k_d[3]  = mkey[31:0]   ^ FK3;
          busy_d  = 1'b1;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        cnt_d   = '0;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (advance) begin
          rk_d   = rk_new;
          idx_d  = cnt_q;
          vld_d  = 1'b1;
          k_d[0] = k_q[1];
          k_d[1] = k_q[2];
          k_d[2] = k_q[3];
          k_d[3] = rk_new;
          // cnt stops at the last index so it never wraps inside a run
          if (cnt_q == LAST) begin
            state_d = ST_FLUSH;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end
      ST_FLUSH: begin
        if (rk_ready) begin
          vld_d   = 1'b0;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
      cnt_q   <= '0;
      rk_q    <= '0;
      idx_q   <= '0;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
      rk_q    <= rk_d;
      idx_q   <= idx_d;
      vld_q   <= vld_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy     = busy_q;
  assign rk_valid = vld_q;
  assign rk_out   = rk_q;
  assign rk_index = idx_q;
  assign done     = done_q;

endmodule

// File: tb/tb_sm4_key_expand.sv
// Bench for sm4_key_expand: word-level SM4 key-schedule model, expected
// queue scoreboard, random backpressure, reset abort and a 4-round build.
module tb_sm4_key_expand;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n, start, rk_ready, busy, rk_valid, done;
  logic [127:0] mkey;
  logic [31:0]  rk_out;
  logic [4:0]   rk_index;

  logic         start4, rk_ready4, busy4, rk_valid4, done4;
  logic [127:0] mkey4;
  logic [31:0]  rk_out4;
  logic [4:0]   rk_index4;

  sm4_key_expand #(.ROUNDS(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mkey(mkey), .busy(busy),
    .rk_valid(rk_valid), .rk_ready(rk_ready), .rk_out(rk_out),
    .rk_index(rk_index), .done(done)
  );

  sm4_key_expand #(.ROUNDS(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .mkey(mkey4), .busy(busy4),
    .rk_valid(rk_valid4), .rk_ready(rk_ready4), .rk_out(rk_out4),
    .rk_index(rk_index4), .done(done4)
  );

  localparam logic [127:0] STD_KEY = 128'h0123456789ABCDEFFEDCBA9876543210;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] sbox_t [256] = '{
    8'hD6, 8'h90, 8'hE9, 8'hFE, 8'hCC, 8'hE1, 8'h3D, 8'hB7, 8'h16, 8'hB6, 8'h14, 8'hC2, 8'h28, 8'hFB, 8'h2C, 8'h05,
    8'h2B, 8'h67, 8'h9A, 8'h76, 8'h2A, 8'hBE, 8'h04, 8'hC3, 8'hAA, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
    8'h9C, 8'h42, 8'h50, 8'hF4, 8'h91, 8'hEF, 8'h98, 8'h7A, 8'h33, 8'h54, 8'h0B, 8'h43, 8'hED, 8'hCF, 8'hAC, 8'h62,
    8'hE4, 8'hB3, 8'h1C, 8'hA9, 8'hC9, 8'h08, 8'hE8, 8'h95, 8'h80, 8'hDF, 8'h94, 8'hFA, 8'h75, 8'h8F, 8'h3F, 8'hA6,
    8'h47, 8'h07, 8'hA7, 8'hFC, 8'hF3, 8'h73, 8'h17, 8'hBA, 8'h83, 8'h59, 8'h3C, 8'h19, 8'hE6, 8'h85, 8'h4F, 8'hA8,
    8'h68, 8'h6B, 8'h81, 8'hB2, 8'h71, 8'h64, 8'hDA, 8'h8B, 8'hF8, 8'hEB, 8'h0F, 8'h4B, 8'h70, 8'h56, 8'h9D, 8'h35,
    8'h1E, 8'h24, 8'h0E, 8'h5E, 8'h63, 8'h58, 8'hD1, 8'hA2, 8'h25, 8'h22, 8'h7C, 8'h3B, 8'h01, 8'h21, 8'h78, 8'h87,
    8'hD4, 8'h00, 8'h46, 8'h57, 8'h9F, 8'hD3, 8'h27, 8'h52, 8'h4C, 8'h36, 8'h02, 8'hE7, 8'hA0, 8'hC4, 8'hC8, 8'h9E,
    8'hEA, 8'hBF, 8'h8A, 8'hD2, 8'h40, 8'hC7, 8'h38, 8'hB5, 8'hA3, 8'hF7, 8'hF2, 8'hCE, 8'hF9, 8'h61, 8'h15, 8'hA1,
    8'hE0, 8'hAE, 8'h5D, 8'hA4, 8'h9B, 8'h34, 8'h1A, 8'h55, 8'hAD, 8'h93, 8'h32, 8'h30, 8'hF5, 8'h8C, 8'hB1, 8'hE3,
    8'h1D, 8'hF6, 8'hE2, 8'h2E, 8'h82, 8'h66, 8'hCA, 8'h60, 8'hC0, 8'h29, 8'h23, 8'hAB, 8'h0D, 8'h53, 8'h4E, 8'h6F,
    8'hD5, 8'hDB, 8'h37, 8'h45, 8'hDE, 8'hFD, 8'h8E, 8'h2F, 8'h03, 8'hFF, 8'h6A, 8'h72, 8'h6D, 8'h6C, 8'h5B, 8'h51,
    8'h8D, 8'h1B, 8'hAF, 8'h92, 8'hBB, 8'hDD, 8'hBC, 8'h7F, 8'h11, 8'hD9, 8'h5C, 8'h41, 8'h1F, 8'h10, 8'h5A, 8'hD8,
    8'h0A, 8'hC1, 8'h31, 8'h88, 8'hA5, 8'hCD, 8'h7B, 8'hBD, 8'h2D, 8'h74, 8'hD0, 8'h12, 8'hB8, 8'hE5, 8'hB4, 8'hB0,
    8'h89, 8'h69, 8'h97, 8'h4A, 8'h0C, 8'h96, 8'h77, 8'h7E, 8'h65, 8'hB9, 8'hF1, 8'h09, 8'hC5, 8'h6E, 8'hC6, 8'h84,
    8'h18, 8'hF0, 8'h7D, 8'hEC, 8'h3A, 8'hDC, 8'h4D, 8'h20, 8'h79, 8'hEE, 8'h5F, 8'h3E, 8'hD7, 8'hCB, 8'h39, 8'h48
  };

  logic [31:0] fk_t [4] = '{32'hA3B1BAC6, 32'h56AA3350, 32'h677D9197, 32'hB27022DC};

  function automatic logic [31:0] m_tprime(input logic [31:0] x);
    logic [31:0] b;
    for (int j = 0; j < 4; j++) b[8*j +: 8] = sbox_t[x[8*j +: 8]];
    return b ^ ((b << 13) | (b >> 19)) ^ ((b << 23) | (b >> 9));
  endfunction

  function automatic logic [31:0] m_ck(input int i);
    logic [31:0] w;
    w = 0;
    for (int j = 0; j < 4; j++) w = (w << 8) | 32'(((4 * i + j) * 7) % 256);
    return w;
  endfunction

  logic [31:0] m_rk [32];

  task automatic model_expand(input logic [127:0] mk);
    logic [31:0] k [36];
    for (int j = 0; j < 4; j++) k[j] = mk[127-32*j -: 32] ^ fk_t[j];
    for (int i = 0; i < 32; i++) begin
      k[i+4]  = k[i] ^ m_tprime(k[i+1] ^ k[i+2] ^ k[i+3] ^ m_ck(i));
      m_rk[i] = k[i+4];
    end
  endtask

  // ---------------- scoreboard / monitor ----------------
  logic [36:0] exp_q [$];
  logic [36:0] e_item;
  int          keys_seen = 0;
  int          done_seen = 0;
  int          exp_done  = 0;
  bit          prev_stall = 0;
  logic [31:0] prev_out;
  logic [4:0]  prev_idx;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", 64'(rk_valid), 64'd1);
        chk("stall_out", 64'(rk_out), 64'(prev_out));
        chk("stall_idx", 64'(rk_index), 64'(prev_idx));
      end
      if (rk_valid && rk_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_key: got idx %0d key %0h want none", rk_index, rk_out);
        end else begin
          e_item = exp_q.pop_front();
          chk("rk_index", 64'(rk_index), 64'(e_item[36:32]));
          chk("rk_out", 64'(rk_out), 64'(e_item[31:0]));
          keys_seen++;
        end
      end
      if (done) done_seen++;
      prev_stall = rk_valid && !rk_ready;
      prev_out   = rk_out;
      prev_idx   = rk_index;
    end
  end

  // ---------------- drivers ----------------
  bit rdy_mode = 0;

  initial begin
    rk_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      rk_ready = (rdy_mode && $urandom_range(0, 1) == 0) ? 1'b0 : 1'b1;
    end
  end

  task automatic push_exp();
    for (int i = 0; i < 32; i++) exp_q.push_back({5'(i), m_rk[i]});
  endtask

  // Called at #1 after a posedge with the DUT idle.
  task automatic start_run(input logic [127:0] mk, input bit hold);
    model_expand(mk);
    push_exp();
    keys_seen = 0;
    mkey  = mk;
    start = 1'b1;
    @(posedge clk);
    #1;
    chk("busy_rise", 64'(busy), 64'd1);
    chk("no_valid_in_load", 64'(rk_valid), 64'd0);
    if (!hold) start = 1'b0;
    mkey = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic wait_done(input bit exact);
    int n;
    bit seen;
    seen = 0;
    for (n = 1; n <= 600; n++) begin
      @(posedge clk);
      #1;
      if (done) begin
        seen = 1;
        break;
      end
    end
    chk("done_seen", 64'(seen), 64'd1);
    if (seen && exact) chk("done_latency", 64'(n), 64'd34);
    chk("busy_after_done", 64'(busy), 64'd0);
    chk("keys_left", 64'(exp_q.size()), 64'd0);
    exp_done++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [127:0] k2;
    int n4, lat4;
    bit hit;
    rst_n = 1'b0;
    start = 1'b0;
    mkey  = '0;
    start4 = 1'b0;
    mkey4  = '0;
    rk_ready4 = 1'b1;
    #12;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_valid", 64'(rk_valid), 64'd0);
    chk("rst_out", 64'(rk_out), 64'd0);
    chk("rst_index", 64'(rk_index), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // model pinned to published values
    model_expand(STD_KEY);
    chk("model_rk0", 64'(m_rk[0]), 64'hF12186F9);
    chk("model_rk1", 64'(m_rk[1]), 64'h41662B61);
    chk("model_rk31", 64'(m_rk[31]), 64'h9124A012);
    chk("model_ck0", 64'(m_ck(0)), 64'h00070E15);
    chk("model_ck31", 64'(m_ck(31)), 64'h646B7279);

    // standard vector, ready held high
    start_run(STD_KEY, 0);
    wait_done(1);

    // random backpressure
    rdy_mode = 1;
    start_run(STD_KEY, 0);
    wait_done(0);
    rdy_mode = 0;

    // start held during run, then accepted right after done
    start_run(STD_KEY, 1);
    wait_done(1);
    k2 = {$urandom, $urandom, $urandom, $urandom};
    model_expand(k2);
    push_exp();
    mkey = k2;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("b2b_busy", 64'(busy), 64'd1);
    wait_done(1);

    // zero key
    start_run('0, 0);
    chk("zero_rk0_model", 64'(m_rk[0]),
        64'(fk_t[0] ^ m_tprime(fk_t[1] ^ fk_t[2] ^ fk_t[3] ^ 32'h00070E15)));
    wait_done(1);

    // random keys with random backpressure
    rdy_mode = 1;
    repeat (3) begin
      start_run({$urandom, $urandom, $urandom, $urandom}, 0);
      wait_done(0);
    end
    rdy_mode = 0;

    repeat (3) @(posedge clk);
    #1;
    chk("done_pulses", 64'(done_seen), 64'(exp_done));

    // asynchronous reset mid-run
    start_run(STD_KEY, 0);
    hit = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      if (keys_seen >= 11) begin
        hit = 1;
        break;
      end
    end
    chk("reached_rk10", 64'(hit), 64'd1);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_valid", 64'(rk_valid), 64'd0);
    chk("arst_out", 64'(rk_out), 64'd0);
    chk("arst_index", 64'(rk_index), 64'd0);
    chk("arst_done", 64'(done), 64'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("arst_no_done", 64'(done_seen), 64'(exp_done));
    start_run(STD_KEY, 0);
    wait_done(1);

    // 4-round build
    model_expand(STD_KEY);
    mkey4  = STD_KEY;
    start4 = 1'b1;
    @(posedge clk);
    #1;
    start4 = 1'b0;
    n4 = 0;
    lat4 = 0;
    hit = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (done4) begin
        hit = 1;
        lat4 = i;
        break;
      end
      if (rk_valid4) begin
        if (n4 < 32) begin
          chk("r4_index", 64'(rk_index4), 64'(n4));
          chk("r4_key", 64'(rk_out4), 64'(m_rk[n4]));
        end
        if (n4 == 0) chk("r4_rk0_literal", 64'(rk_out4), 64'hF12186F9);
        if (n4 == 1) chk("r4_rk1_literal", 64'(rk_out4), 64'h41662B61);
        n4++;
      end
    end
    chk("r4_done_seen", 64'(hit), 64'd1);
    chk("r4_key_count", 64'(n4), 64'd4);
    chk("r4_latency", 64'(lat4), 64'd6);
    chk("r4_busy_after", 64'(busy4), 64'd0);

    repeat (3) @(posedge clk);
    #1;
    chk("final_done_pulses", 64'(done_seen), 64'(exp_done));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sm4_key_expand.md
Name: sm4_key_expand

Overview:
Iterative SM4 key-schedule engine that turns a 128-bit master key into the 32 round keys rk0..rk31. It produces one key per cycle on a valid/ready stream. The block sits directly upstream of the round datapath, which consumes rk_out. Its nonlinear step instantiates the existing SM4 byte S-box four times (tau), followed by the key-schedule linear transform L'.

Parameters:
ROUNDS, 32, number of round keys emitted per run; legal range 1..32; 32 for standard SM4, smaller values are for bench shortening only.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request a new expansion; sampled only in IDLE
mkey  input  128  master key MK0..MK3, MK0 = bits [127:96]
busy  output  1  high from the cycle after start is accepted until done
rk_valid  output  1  rk_out/rk_index hold a valid round key
rk_ready  input  1  downstream accepts the key on (rk_valid && rk_ready)
rk_out  output  32  round key
rk_index  output  5  index i of rk_out (0..ROUNDS-1)
done  output  1  one-cycle pulse when the last key is accepted

Behaviour:
- Reset: one clock; reset is asynchronous and active-low. On reset all outputs are 0 (busy, rk_valid, rk_out, rk_index, done), the state is IDLE, and K0..K3 are 0. Reset mid-run aborts silently with no done pulse.
- FK constants: A3B1BAC6, 56AA3350, 677D9197, B27022DC.
- CK_i: byte j (j=0 is the MSB) = ((4i+j)*7) mod 256, computed with 8-bit wraparound arithmetic. CK0 = 00070E15 and CK31 = 646B7279. CK comes from a function or a ROM; either is acceptable.
- Per-round transform: T'(x) = L'(tau(x)), with L'(B) = B ^ (B<<<13) ^ (B<<<23). tau applies the S-box to each byte of x independently.
- Round step: rk_i = K_i ^ T'(K_{i+1} ^ K_{i+2} ^ K_{i+3} ^ CK_i). The K registers then shift: K0<=K1, K1<=K2, K2<=K3, K3<=rk_i.
- States: IDLE, LOAD, RUN, FLUSH.
- IDLE: start=1 latches K_j <= MK_j ^ FK_j and moves to LOAD; busy rises next cycle.
- LOAD: one cycle, moves to RUN. The round counter cnt is set to 0.
- RUN: whenever (!rk_valid || rk_ready), the block computes rk_cnt, registers it into rk_out with rk_index=cnt and rk_valid=1, shifts K, and increments cnt. After key ROUNDS-1 is issued it moves to FLUSH.
- FLUSH: rk_valid stays high until rk_ready. On acceptance: rk_valid=0, done=1 for one cycle, busy=0, return to IDLE.
- Latency: start accepted at edge E0 gives rk0 valid after edge E2. With rk_ready held high, one key per cycle follows, and done is asserted 2+ROUNDS cycles after E0.
- Backpressure: while rk_valid && !rk_ready, rk_out, rk_index, K and cnt all hold. No key is skipped or duplicated.
- start while busy is ignored. mkey is only sampled in IDLE on start.
- start may be asserted in the same cycle done is high; it is accepted on the following cycle, since IDLE is reached after the done edge.
- cnt is 5 bits and never wraps within a run; the RUN→FLUSH decision uses cnt == ROUNDS-1.

Decomposition:
- Shared package sm4_pkg: FK0..FK3 constants, the ROUNDS range limit, a ck_word(i) function, and rotl32 / L_key (L') functions. The round datapath reuses rotl32 for its own L transform.
- Sub-module sm4_tau: 32-bit in, 32-bit out, purely combinational, built from four S-box instances. The round datapath reuses it.

Test Plan:
1. Standard vector: mkey=0123456789ABCDEFFEDCBA9876543210, rk_ready=1 → rk0=F12186F9, rk1=41662B61, rk31=9124A012, rk_index 0..31 consecutive, done exactly 2+32 cycles after start.
2. Backpressure: same key, rk_ready toggled by random 50% pattern → identical 32-key sequence, outputs stable while stalled, single done pulse.
3. start held high during run with a different mkey → sequence unchanged, no second run until IDLE; back-to-back start on the done cycle yields a second correct run.
4. mkey=0 → rk0 = FK0 ^ T'(FK1^FK2^FK3^00070E15), checked against the model; CK31 path exercised (rk31 matches the model).
5. Reset asserted asynchronously mid-run (after rk10) → all outputs 0 immediately, no done; a fresh start then produces the full correct sequence.
6. ROUNDS=4 build → exactly 4 keys (F12186F9, 41662B61, ...), done after key 3.
